// File: rtl/fizzbuzz_emitter.sv
// Serialises one classified number per handshake into an ASCII line
// ("Fizz", "Buzz", "FizzBuzz" or decimal digits) followed by a separator byte.
module fizzbuzz_emitter #(
  parameter logic [7:0] SEP      = 8'h0A,
  parameter logic       CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_number,
  input  logic       in_fizz,
  input  logic       in_buzz,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TEXT   = 2'd1,
    ST_DIGITS = 2'd2,
    ST_SEP    = 2'd3
  } state_t;

  state_t     state_r, state_nx_s;
  logic [2:0] idx_r, idx_nx_s;
  logic       fizz_r, fizz_nx_s;
  logic       buzz_r, buzz_nx_s;
  logic [3:0] hun_r, hun_nx_s;
  logic [3:0] ten_r, ten_nx_s;
  logic [3:0] one_r, one_nx_s;
  logic       in_ready_r, in_ready_nx_s;
  logic       out_valid_r, out_valid_nx_s;
  logic [7:0] out_data_r, out_data_nx_s;
  logic       out_last_r, out_last_nx_s;
  logic       err_r, err_nx_s;

  logic       accept_s;
  logic       take_s;
  logic [3:0] in_hun_s, in_ten_s, in_one_s;
  logic [2:0] in_pos_s;
  logic [2:0] text_last_s;

  // "Buzz" alone reuses the second half of "FizzBuzz"
  function automatic logic [7:0] text_byte(input logic fz, input logic bz,
                                           input logic [2:0] idx);
    logic [2:0] k;
    k = (bz && !fz) ? (idx + 3'd4) : idx;
    case (k)
      3'd0:    text_byte = 8'h46;
      3'd1:    text_byte = 8'h69;
      3'd2:    text_byte = 8'h7A;
      3'd3:    text_byte = 8'h7A;
      3'd4:    text_byte = 8'h42;
      3'd5:    text_byte = 8'h75;
      3'd6:    text_byte = 8'h7A;
      3'd7:    text_byte = 8'h7A;
      default: text_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] digit_byte(input logic [3:0] h, input logic [3:0] t,
                                            input logic [3:0] o, input logic [2:0] pos);
    logic [3:0] d;
    case (pos)
      3'd0:    d = h;
      3'd1:    d = t;
      default: d = o;
    endcase
    digit_byte = 8'h30 + {4'h0, d};
  endfunction

  function automatic logic flags_bad(input logic [7:0] n, input logic fz, input logic bz);
    logic div3;
    logic div5;
    div3 = ((n % 8'd3) == 8'd0);
    div5 = ((n % 8'd5) == 8'd0);
    flags_bad = (fz != div3) || (bz != div5);
  endfunction

  assign accept_s    = in_valid && in_ready_r;
  assign take_s      = out_valid_r && out_ready;
  assign text_last_s = (fizz_r && buzz_r) ? 3'd7 : 3'd3;

  // Decimal split of the incoming number; in_pos_s is the first non-suppressed digit
  always_comb begin
    in_hun_s = 4'(in_number / 8'd100);
    in_ten_s = 4'((in_number / 8'd10) % 8'd10);
    in_one_s = 4'(in_number % 8'd10);
    if (in_number >= 8'd100) begin
      in_pos_s = 3'd0;
    end else if (in_number >= 8'd10) begin
      in_pos_s = 3'd1;
    end else begin
      in_pos_s = 3'd2;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx_s     = state_r;
    idx_nx_s       = idx_r;
    fizz_nx_s      = fizz_r;
    buzz_nx_s      = buzz_r;
    hun_nx_s       = hun_r;
    ten_nx_s       = ten_r;
    one_nx_s       = one_r;
    in_ready_nx_s  = in_ready_r;
    out_valid_nx_s = out_valid_r;
    out_data_nx_s  = out_data_r;
    out_last_nx_s  = out_last_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          fizz_nx_s      = in_fizz;
          buzz_nx_s      = in_buzz;
          hun_nx_s       = in_hun_s;
          ten_nx_s       = in_ten_s;
          one_nx_s       = in_one_s;
          in_ready_nx_s  = 1'b0;
          out_valid_nx_s = 1'b1;
          out_last_nx_s  = 1'b0;
          if (in_fizz || in_buzz) begin
            state_nx_s    = ST_TEXT;
            idx_nx_s      = 3'd0;
            out_data_nx_s = text_byte(in_fizz, in_buzz, 3'd0);
          end else begin
            state_nx_s    = ST_DIGITS;
            idx_nx_s      = in_pos_s;
            out_data_nx_s = digit_byte(in_hun_s, in_ten_s, in_one_s, in_pos_s);
          end
        end else begin
          in_ready_nx_s  = 1'b1;
          out_valid_nx_s = 1'b0;
          out_data_nx_s  = 8'h00;
          out_last_nx_s  = 1'b0;
        end
      end
      ST_TEXT: begin
        if (take_s && (idx_r == text_last_s)) begin
          state_nx_s    = ST_SEP;
          out_data_nx_s = SEP;
          out_last_nx_s = 1'b1;
        end else if (take_s) begin
          idx_nx_s      = idx_r + 3'd1;
          out_data_nx_s = text_byte(fizz_r, buzz_r, idx_r + 3'd1);
        end else begin
          out_data_nx_s = out_data_r;
        end
      end
      ST_DIGITS: begin
        if (take_s && (idx_r == 3'd2)) begin
          state_nx_s    = ST_SEP;
          out_data_nx_s = SEP;
          out_last_nx_s = 1'b1;
        end else if (take_s) begin
          idx_nx_s      = idx_r + 3'd1;
          out_data_nx_s = digit_byte(hun_r, ten_r, one_r, idx_r + 3'd1);
        end else begin
          out_data_nx_s = out_data_r;
        end
      end
      ST_SEP: begin
        if (take_s) begin
          state_nx_s     = ST_IDLE;
          in_ready_nx_s  = 1'b1;
          out_valid_nx_s = 1'b0;
          out_data_nx_s  = 8'h00;
          out_last_nx_s  = 1'b0;
        end else begin
          out_data_nx_s = out_data_r;
        end
      end
      default: begin
        state_nx_s     = ST_IDLE;
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
        out_data_nx_s  = 8'h00;
        out_last_nx_s  = 1'b0;
      end
    endcase
  end

  // Sticky checker: flags are emitted as given, only the mismatch is recorded
  always_comb begin
    if (CHECK_EN && accept_s && flags_bad(in_number, in_fizz, in_buzz)) begin
      err_nx_s = 1'b1;
    end else begin
      err_nx_s = err_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      fizz_r      <= 1'b0;
      buzz_r      <= 1'b0;
      hun_r       <= 4'd0;
      ten_r       <= 4'd0;
      one_r       <= 4'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_last_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      idx_r       <= idx_nx_s;
      fizz_r      <= fizz_nx_s;
      buzz_r      <= buzz_nx_s;
      hun_r       <= hun_nx_s;
      ten_r       <= ten_nx_s;
      one_r       <= one_nx_s;
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
      out_data_r  <= out_data_nx_s;
      out_last_r  <= out_last_nx_s;
      err_r       <= err_nx_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign err       = err_r;

endmodule

// File: tb/tb_fizzbuzz_emitter.sv
// Directed bench for fizzbuzz_emitter: a table of lines with hand-computed
// byte streams, plus a mid-line reset sequence.
module tb_fizzbuzz_emitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_number = 8'd0;
  logic       in_fizz = 1'b0;
  logic       in_buzz = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  num;
    logic        fz;
    logic        bz;
    int          nb;
    logic [71:0] bytes;
    int          stall_idx;
    int          stall_len;
    logic        err_exp;
  } vec_t;

  vec_t vecs[14];

  fizzbuzz_emitter #(.SEP(8'h0A), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_number(in_number), .in_fizz(in_fizz), .in_buzz(in_buzz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic send_line(input vec_t v);
    int got;
    int cyc;
    int stalled;
    logic [7:0] held;
    got = 0;
    cyc = 0;
    stalled = 0;
    held = 8'h00;
    check("ready_before", in_ready, 1);
    in_valid  = 1'b1;
    in_number = v.num;
    in_fizz   = v.fz;
    in_buzz   = v.bz;
    @(negedge clk);
    in_valid  = 1'b0;
    in_number = 8'($urandom);
    in_fizz   = 1'($urandom);
    in_buzz   = 1'($urandom);
    check("ready_after_accept", in_ready, 0);
    check("err_after_accept", err, v.err_exp);
    while (got < v.nb && cyc < 60) begin
      if (v.stall_idx == got && stalled < v.stall_len) begin
        out_ready = 1'b0;
        if (stalled == 0) begin
          held = out_data;
        end else begin
          check("hold_data", out_data, held);
          check("hold_valid", out_valid, 1);
        end
        stalled++;
      end else begin
        out_ready = 1'b1;
        check("valid", out_valid, 1);
        check("data", out_data, v.bytes[71 - 8*got -: 8]);
        check("last", out_last, (got == v.nb - 1) ? 1 : 0);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check("byte_count", got, v.nb);
    check("line_cycles", cyc, v.nb + v.stall_len);
    check("idle_valid", out_valid, 0);
    check("idle_ready", in_ready, 1);
  endtask

  initial begin
    vec_t v1;
    vecs[0]  = '{8'd7,   1'b0, 1'b0, 2, 72'h37_0A_00_00_00_00_00_00_00, -1, 0, 1'b0};
    vecs[1]  = '{8'd15,  1'b1, 1'b1, 9, 72'h46_69_7A_7A_42_75_7A_7A_0A, -1, 0, 1'b0};
    vecs[2]  = '{8'd101, 1'b0, 1'b0, 4, 72'h31_30_31_0A_00_00_00_00_00, -1, 0, 1'b0};
    vecs[3]  = '{8'd0,   1'b1, 1'b1, 9, 72'h46_69_7A_7A_42_75_7A_7A_0A, -1, 0, 1'b0};
    vecs[4]  = '{8'd58,  1'b0, 1'b0, 3, 72'h35_38_0A_00_00_00_00_00_00, -1, 0, 1'b0};
    vecs[5]  = '{8'd203, 1'b0, 1'b0, 4, 72'h32_30_33_0A_00_00_00_00_00, -1, 0, 1'b0};
    vecs[6]  = '{8'd10,  1'b0, 1'b1, 5, 72'h42_75_7A_7A_0A_00_00_00_00, -1, 0, 1'b0};
    vecs[7]  = '{8'd9,   1'b1, 1'b0, 5, 72'h46_69_7A_7A_0A_00_00_00_00,  1, 3, 1'b0};
    vecs[8]  = '{8'd100, 1'b0, 1'b1, 5, 72'h42_75_7A_7A_0A_00_00_00_00, -1, 0, 1'b0};
    vecs[9]  = '{8'd4,   1'b1, 1'b0, 5, 72'h46_69_7A_7A_0A_00_00_00_00, -1, 0, 1'b1};
    vecs[10] = '{8'd255, 1'b0, 1'b0, 4, 72'h32_35_35_0A_00_00_00_00_00, -1, 0, 1'b1};
    vecs[11] = '{8'd7,   1'b0, 1'b0, 2, 72'h37_0A_00_00_00_00_00_00_00,  0, 2, 1'b1};
    vecs[12] = '{8'd1,   1'b0, 1'b0, 2, 72'h31_0A_00_00_00_00_00_00_00, -1, 0, 1'b1};
    vecs[13] = '{8'd30,  1'b1, 1'b1, 9, 72'h46_69_7A_7A_42_75_7A_7A_0A,  8, 2, 1'b1};

    // Reset state
    #2;
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_last", out_last, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_low_at_release", in_ready, 0);
    @(negedge clk);
    check("ready_after_release", in_ready, 1);

    for (int i = 0; i < 14; i++) begin
      send_line(vecs[i]);
      check("err_after_line", err, vecs[i].err_exp);
    end

    // Mid-line reset: three bytes of "FizzBuzz" taken, then rst_n asserted
    in_valid  = 1'b1;
    in_number = 8'd0;
    in_fizz   = 1'b1;
    in_buzz   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("mid_first", out_data, 8'h46);
    repeat (3) @(negedge clk);
    check("mid_fourth", out_data, 8'h7A);
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_ready", in_ready, 0);
    check("async_data", out_data, 8'h00);
    check("async_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v1 = '{8'd1, 1'b0, 1'b0, 2, 72'h31_0A_00_00_00_00_00_00_00, -1, 0, 1'b0};
    send_line(v1);
    repeat (2) @(negedge clk);
    check("stay_idle_valid", out_valid, 0);
    check("stay_idle_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
